lfsr_delay_gen: RTL and testbench

Parametrised pseudo-random delay generator for the reaction-timer datapath. A configurable-width Fibonacci LFSR runs off the game clock, and a countdown engine turns one LFSR sample into a random wait measured in `tick` periods. At the end of the wait it raises a one-cycle `done` pulse, which the game FSM uses to light the "GO" stimulus. It generalises the fixed 12-bit shift register by adding parametrised width, taps, seed and recovery value, an enable, and a start/abort/done handshake.

---
 rtl/lfsr_delay_gen.sv | 119 +++++++++++
 tb/tb_lfsr_delay_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_delay_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_delay_gen
// Brief    : Fibonacci LFSR plus a countdown engine that turns one LFSR sample
//            into a random wait, in tick periods, ending in a one-cycle done.
// Revision : 1.0  initial release
// ============================================================================
module lfsr_delay_gen #(
    parameter int               WIDTH      = 12,
    parameter logic [WIDTH-1:0] TAPS       = 12'h060,
    parameter logic [WIDTH-1:0] SEED       = 12'h4AD,
    parameter logic [WIDTH-1:0] RECOVER    = 12'h00D,
    parameter int               DW         = 16,
    parameter int               RANGE_BITS = 10,
    parameter int               MIN_DELAY  = 500
) (
    input  logic             cin,
    input  logic             resetn,
    input  logic             en,
    input  logic             tick,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] rnd,
    output logic [DW-1:0]    delay_out,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0]    c_IDLE      = 2'd0;
    localparam logic [1:0]    c_COUNT     = 2'd1;
    localparam logic [1:0]    c_FIRE      = 2'd2;
    localparam logic [DW-1:0] c_MIN_DELAY = DW'(MIN_DELAY);

    logic [WIDTH-1:0] r_lfsr_q;
    logic [WIDTH-1:0] w_lfsr_d;
    logic [1:0]       r_state_q;
    logic [1:0]       w_state_d;
    logic [DW-1:0]    r_cnt_q;
    logic [DW-1:0]    w_cnt_d;
    logic [DW-1:0]    r_delay_q;
    logic [DW-1:0]    w_delay_d;
    logic [DW-1:0]    w_offset;
    logic [DW-1:0]    w_new_delay;

    // An all-zero register would lock up the shifter, so it is reseeded first.
    always_comb begin
        w_lfsr_d = r_lfsr_q;
        if (en) begin
            if (r_lfsr_q == '0) begin
                w_lfsr_d = RECOVER;
            end else begin
                w_lfsr_d = {r_lfsr_q[WIDTH-2:0], ^(r_lfsr_q & TAPS)};
            end
        end
    end

    // Offset is taken from the pre-shift LFSR value of the accepting edge.
    always_comb begin
        w_offset                   = '0;
        w_offset[RANGE_BITS-1:0]   = r_lfsr_q[RANGE_BITS-1:0];
        w_new_delay                = c_MIN_DELAY + w_offset;
    end

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_delay_d = r_delay_q;
        case (r_state_q)
            c_IDLE: begin
                if (start && !abort) begin
                    w_delay_d = w_new_delay;
                    w_cnt_d   = w_new_delay;
                    w_state_d = (w_new_delay != '0) ? c_COUNT : c_FIRE;
                end
            end
            c_COUNT: begin
                if (abort) begin
                    w_cnt_d   = '0;
                    w_state_d = c_IDLE;
                end else if (tick) begin
                    if (r_cnt_q == DW'(1)) begin
                        w_cnt_d   = '0;
                        w_state_d = c_FIRE;
                    end else begin
                        w_cnt_d = r_cnt_q - DW'(1);
                    end
                end
            end
            c_FIRE: begin
                w_state_d = c_IDLE;
            end
            default: begin
                w_state_d = c_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge cin or negedge resetn) begin
        if (!resetn) begin
            r_lfsr_q  <= SEED;
            r_state_q <= c_IDLE;
            r_cnt_q   <= '0;
            r_delay_q <= '0;
        end else begin
            r_lfsr_q  <= w_lfsr_d;
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_delay_q <= w_delay_d;
        end
    end

    assign rnd       = r_lfsr_q;
    assign delay_out = r_delay_q;
    assign busy      = (r_state_q == c_COUNT);
    assign done      = (r_state_q == c_FIRE);

endmodule
`default_nettype wire

// File: tb/tb_lfsr_delay_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_delay_gen
// Brief    : Directed stimulus for lfsr_delay_gen with a cycle-level reference
//            model and hand-computed anchor values.
// Revision : 1.0  initial release
// ============================================================================
module tb_lfsr_delay_gen;

    logic        cin;
    logic        resetn;
    logic        en;
    logic        tick;
    logic        start;
    logic        abort;
    logic        start1;
    logic        abort1;
    logic        tick1;
    logic [11:0] rnd0;
    logic [11:0] rnd1;
    logic [15:0] delay_out0;
    logic [15:0] delay_out1;
    logic        busy0;
    logic        busy1;
    logic        done0;
    logic        done1;

    int vectors    = 0;
    int miscompares = 0;
    int done_cnt   = 0;
    bit chk_on     = 0;

    // Reference model state
    logic [11:0] m_r0;
    logic [11:0] m_r1;
    int          m_delay;
    int          m_left;
    bit          m_busy;
    bit          m_fire;

    lfsr_delay_gen u_dut (
        .cin       (cin),
        .resetn    (resetn),
        .en        (en),
        .tick      (tick),
        .start     (start),
        .abort     (abort),
        .rnd       (rnd0),
        .delay_out (delay_out0),
        .busy      (busy0),
        .done      (done0)
    );

    lfsr_delay_gen #(.SEED(12'h000)) u_dut_zero (
        .cin       (cin),
        .resetn    (resetn),
        .en        (en),
        .tick      (tick1),
        .start     (start1),
        .abort     (abort1),
        .rnd       (rnd1),
        .delay_out (delay_out1),
        .busy      (busy1),
        .done      (done1)
    );

    initial begin
        cin = 1'b0;
        forever #5 cin = ~cin;
    end

    function automatic logic [11:0] lfsr_next(input logic [11:0] r);
        if (r == 12'h000) return 12'h00D;
        return {r[10:0], r[5] ^ r[6]};
    endfunction

    always @(posedge cin or negedge resetn) begin
        if (!resetn) begin
            m_r0 = 12'h4AD; m_r1 = 12'h000;
            m_delay = 0; m_left = 0; m_busy = 0; m_fire = 0;
        end else begin
            if (m_fire) begin
                m_fire = 0;
            end else if (m_busy) begin
                if (abort) begin
                    m_busy = 0; m_left = 0;
                end else if (tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin m_busy = 0; m_fire = 1; end
                end
            end else if (start && !abort) begin
                m_delay = 500 + int'(m_r0 % 1024);
                m_left  = m_delay;
                if (m_delay == 0) m_fire = 1; else m_busy = 1;
            end
            if (en) begin
                m_r0 = lfsr_next(m_r0);
                m_r1 = lfsr_next(m_r1);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge cin) begin
        if (done0 === 1'b1) done_cnt++;
        if (chk_on) begin
            chk("rnd", 32'(rnd0), 32'(m_r0));
            chk("delay_out", 32'(delay_out0), 32'(m_delay));
            chk("busy", 32'(busy0), 32'(m_busy));
            chk("done", 32'(done0), 32'(m_fire));
            chk("rnd_seed0", 32'(rnd1), 32'(m_r1));
        end
    end

    task automatic step();
        @(posedge cin);
        #1;
    endtask

    initial begin
        int busy_cycles;
        int dc0;
        int saved;
        bit seen;

        resetn = 1'b1; en = 0; tick = 0; start = 0; abort = 0;
        start1 = 0; abort1 = 0; tick1 = 0;
        #1 resetn = 1'b0;
        #1 chk_on = 1;
        repeat (2) step();
        resetn = 1'b1;

        // Reset values and LFSR sequence anchors
        chk("rst_rnd", 32'(rnd0), 32'h4AD);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_done", 32'(done0), 32'h0);
        chk("rst_delay", 32'(delay_out0), 32'h0);
        chk("rst_rnd_seed0", 32'(rnd1), 32'h000);
        en = 1; step(); en = 0;
        chk("shift1", 32'(rnd0), 32'h95B);
        chk("recover", 32'(rnd1), 32'h00D);
        en = 1; step(); en = 0;
        chk("recover_shift", 32'(rnd1), 32'h01A);
        step();
        chk("en_hold", 32'(rnd1), 32'h01A);

        // Full-length run from a fresh reset, tick every cycle
        resetn = 1'b0; #2 resetn = 1'b1;
        start = 1; tick = 1; step(); start = 0;
        chk("delay_673", 32'(delay_out0), 32'd673);
        busy_cycles = busy0 ? 1 : 0;
        dc0 = done_cnt;
        seen = 0;
        for (int i = 0; i < 800 && !seen; i++) begin
            step();
            if (done0) seen = 1;
            else if (busy0) busy_cycles++;
        end
        chk("done_seen", 32'(seen), 32'h1);
        chk("busy_len", 32'(busy_cycles), 32'd673);
        chk("done_busy_low", 32'(busy0), 32'h0);
        step();
        chk("done_one_cycle", 32'(done0), 32'h0);
        chk("done_count", 32'(done_cnt - dc0), 32'd1);
        tick = 0;

        // Abort after 10 ticks
        en = 1;
        start = 1; step(); start = 0;
        saved = m_delay;
        repeat (10) begin tick = 1; step(); tick = 0; step(); end
        abort = 1; step(); abort = 0;
        chk("abort_busy", 32'(busy0), 32'h0);
        chk("abort_delay_held", 32'(delay_out0), 32'(saved));
        dc0 = done_cnt;
        tick = 1; repeat (30) step(); tick = 0;
        chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);

        // Start held high through the whole run, including FIRE
        start = 1; tick = 1; step();
        saved = m_delay;
        dc0 = done_cnt;
        seen = 0;
        for (int i = 0; i < 1600 && !seen; i++) begin
            step();
            if (done0) seen = 1;
            else chk("start_ignored", 32'(delay_out0), 32'(saved));
        end
        chk("held_done_seen", 32'(seen), 32'h1);
        step();
        chk("fire_start_dropped", 32'(busy0), 32'h0);
        step();
        chk("restart_after_done", 32'(busy0), 32'h1);
        chk("single_done", 32'(done_cnt - dc0), 32'd1);
        start = 0; tick = 0;
        abort = 1; step(); abort = 0;

        // Asynchronous reset with cnt = 200
        start = 1; step(); start = 0;
        tick = 1;
        for (int i = 0; i < 1600 && m_left != 200; i++) step();
        tick = 0;
        chk("reached_200", 32'(m_left), 32'd200);
        @(negedge cin); #2 resetn = 1'b0;
        #1;
        chk("async_busy", 32'(busy0), 32'h0);
        chk("async_rnd", 32'(rnd0), 32'h4AD);
        chk("async_delay", 32'(delay_out0), 32'h0);
        repeat (2) step();
        resetn = 1'b1;
        dc0 = done_cnt;
        tick = 1; repeat (30) step(); tick = 0;
        chk("reset_no_done", 32'(done_cnt - dc0), 32'd0);
        en = 0;

        @(posedge cin); #2;
        chk_on = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
